// File: rtl/i2s_tx.sv
// i2s_tx: valid/ready sink for the voice mix; scales TONE_IN and serialises it as a mono Philips I2S stream.
// Optional build macro I2S_TX_SATURATE_EN: clamp out-of-range mixes instead of wrapping them.
module i2s_tx #(
    parameter int BCLK_DIV = 8,
    parameter int CH_BITS  = 32,
    parameter int SAMPLE_W = 16,
    parameter int SHIFT    = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] TONE_IN,
    input  logic        TONE_VALID,
    output logic        TONE_READY,
    output logic        SAMPLE_REQ,
    output logic        UNDERRUN,
    output logic        I2S_BCLK,
    output logic        I2S_LRCLK,
    output logic        I2S_SDATA
);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int FRAME_BITS = 2 * CH_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int TOP        = SHIFT + SAMPLE_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] CH_LEN   = BIT_W'(CH_BITS);

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_next;
    logic [BIT_W-1:0]    slot_pos;
    logic                fall_ev;
    logic                frame_start;
    logic                accept;
    logic                holding_full;
    logic                next_bit;
    logic [SAMPLE_W-1:0] holding;
    logic [SAMPLE_W-1:0] frame_sample;
    logic [SAMPLE_W-1:0] scaled;
    logic                unused_tone;

    // Bits below SHIFT (and above the sample in wrap mode) are deliberately discarded.
    assign unused_tone = ^TONE_IN;

    assign fall_ev     = (div_cnt == DIV_LAST) && I2S_BCLK;
    assign frame_start = fall_ev && (bit_cnt == BIT_LAST);
    assign bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign slot_pos    = (bit_next >= CH_LEN) ? bit_next - CH_LEN : bit_next;
    assign accept      = TONE_VALID && !holding_full;
    assign TONE_READY  = !holding_full;

    // Slot position 0 is the I2S one-bit delay; the sample follows MSB first, then zero padding.
    always_comb begin
        next_bit = 1'b0;
        for (int p = 1; p <= SAMPLE_W; p++) begin
            if (slot_pos == BIT_W'(p)) next_bit = frame_sample[SAMPLE_W-p];
        end
    end

    always_comb begin
        scaled = TONE_IN[TOP:SHIFT];
`ifdef I2S_TX_SATURATE_EN
        if (!((&TONE_IN[31:TOP]) || !(|TONE_IN[31:TOP]))) begin
            scaled = TONE_IN[31] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            I2S_BCLK  <= 1'b0;
            I2S_LRCLK <= 1'b0;
            I2S_SDATA <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                I2S_BCLK <= ~I2S_BCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_ev) begin
                bit_cnt   <= bit_next;
                I2S_LRCLK <= (bit_next >= CH_LEN);
                I2S_SDATA <= next_bit;
            end
        end
    end

    // NOTE: the sample registers are reset too, so a frame after reset plays silence, not stale data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            holding_full <= 1'b0;
            holding      <= '0;
            frame_sample <= '0;
            SAMPLE_REQ   <= 1'b0;
            UNDERRUN     <= 1'b0;
        end else begin
            SAMPLE_REQ <= frame_start;
            UNDERRUN   <= frame_start && !holding_full;
            // accept is impossible while full, so the load and a new accept never collide.
            if (frame_start && holding_full) begin
                frame_sample <= holding;
                holding_full <= 1'b0;
            end else if (accept) begin
                holding      <= scaled;
                holding_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: random and directed mixes, every output compared each cycle against a cycle-count model.
module tb_i2s_tx;
    localparam int BCLK_DIV  = 8;
    localparam int CH_BITS   = 32;
    localparam int SAMPLE_W  = 16;
    localparam int SHIFT     = 15;
    localparam int FRAME_CYC = 2 * BCLK_DIV * 2 * CH_BITS;
`ifdef I2S_TX_SATURATE_EN
    localparam longint S_MAX = (longint'(1) << (SAMPLE_W - 1)) - 1;
    localparam longint S_MIN = -(longint'(1) << (SAMPLE_W - 1));
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [31:0] TONE_IN = '0;
    logic        TONE_VALID = 1'b0;
    logic        TONE_READY;
    logic        SAMPLE_REQ;
    logic        UNDERRUN;
    logic        I2S_BCLK;
    logic        I2S_LRCLK;
    logic        I2S_SDATA;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    i2s_tx #(
        .BCLK_DIV(BCLK_DIV),
        .CH_BITS (CH_BITS),
        .SAMPLE_W(SAMPLE_W),
        .SHIFT   (SHIFT)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .TONE_IN   (TONE_IN),
        .TONE_VALID(TONE_VALID),
        .TONE_READY(TONE_READY),
        .SAMPLE_REQ(SAMPLE_REQ),
        .UNDERRUN  (UNDERRUN),
        .I2S_BCLK  (I2S_BCLK),
        .I2S_LRCLK (I2S_LRCLK),
        .I2S_SDATA (I2S_SDATA)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Sample value as a signed number: arithmetic shift, then clamp or keep the low bits.
    function automatic logic [SAMPLE_W-1:0] scale(input logic [31:0] t);
        longint v;
        v = longint'($signed(t)) >>> SHIFT;
`ifdef I2S_TX_SATURATE_EN
        if (v > S_MAX) v = S_MAX;
        else if (v < S_MIN) v = S_MIN;
`endif
        return v[SAMPLE_W-1:0];
    endfunction

    // Reference model: cycles since reset release decide every output; holding tracked as a flag.
    int unsigned         cyc;
    logic                m_full;
    logic [SAMPLE_W-1:0] m_hold;
    logic [SAMPLE_W-1:0] m_cur;
    logic                m_v;
    logic [31:0]         m_d;
    logic                m_fs;
    logic                m_under;
    int                  bitc;
    int                  pos;
    logic                e_sd;

    always @(posedge CLK) begin
        if (!RESET_N) begin
            cyc    = 0;
            m_full = 1'b0;
            m_hold = '0;
            m_cur  = '0;
        end else begin
            m_v = TONE_VALID;
            m_d = TONE_IN;
            cyc++;
            m_fs    = (cyc % FRAME_CYC) == 0;
            m_under = m_fs && !m_full;
            if (m_fs && m_full) begin
                m_cur  = m_hold;
                m_full = 1'b0;
            end else if (m_v && !m_full) begin
                m_hold = scale(m_d);
                m_full = 1'b1;
            end
            bitc = int'((cyc / (2 * BCLK_DIV)) % (2 * CH_BITS));
            pos  = bitc % CH_BITS;
            e_sd = (pos >= 1 && pos <= SAMPLE_W) ? m_cur[SAMPLE_W-pos] : 1'b0;
            #1;
            if (RESET_N) begin
                check("bclk", I2S_BCLK, (cyc / BCLK_DIV) % 2);
                check("lrclk", I2S_LRCLK, bitc >= CH_BITS);
                check("sdata", I2S_SDATA, e_sd);
                check("sample_req", SAMPLE_REQ, m_fs);
                check("underrun", UNDERRUN, m_under);
                check("tone_ready", TONE_READY, !m_full);
            end
        end
    end

    task automatic reset_state(input string tag);
        check({tag, "_bclk"}, I2S_BCLK, 0);
        check({tag, "_lrclk"}, I2S_LRCLK, 0);
        check({tag, "_sdata"}, I2S_SDATA, 0);
        check({tag, "_sample_req"}, SAMPLE_REQ, 0);
        check({tag, "_underrun"}, UNDERRUN, 0);
        check({tag, "_tone_ready"}, TONE_READY, 1);
    endtask

    // Hold VALID with the value until a rising edge sees READY; VALID stays high afterwards.
    task automatic send(input logic [31:0] val);
        logic rdy;
        logic done;
        done = 1'b0;
        @(negedge CLK);
        TONE_IN    = val;
        TONE_VALID = 1'b1;
        for (int n = 0; n < 3 * FRAME_CYC && !done; n++) begin
            rdy = TONE_READY;
            @(posedge CLK);
            if (rdy) done = 1'b1;
            else @(negedge CLK);
        end
        check("send_accepted", done, 1);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        TONE_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] r;
        #1 RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #2 reset_state("por");
        @(negedge CLK);
        RESET_N = 1'b1;

        // Back-to-back held VALID: A, B, C land in frames 1, 2, 3.
        send(32'h0000_8000);
        send(32'hFFFF_8000);
        send(32'h4000_0000);
        // Starve for two frames so the last sample repeats with UNDERRUN.
        idle(2 * FRAME_CYC + 100);

        send(32'h1234_5678);
        idle(200);
        // Mid-frame asynchronous reset with the holding register full.
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1 reset_state("mid_reset");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 0) r = {{15{r[16]}}, r[16:0]};
            send(r);
            idle(int'($urandom_range(1500, 0)));
        end
        idle(2 * FRAME_CYC + 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
